sync_down_cnt: RTL and testbench
================================

// Module: sync_down_cnt
// PURPOSE
//  Loadable synchronous down counter, the count-down companion to the team's synchronous up counters.
//  Counts a preset value down to zero.
//  Stops at zero (one-shot) or reloads itself (auto-reload, divide-by-(D+1)).
//  BORROW is asserted on terminal count so stages can cascade or drive timers/dividers downstream.
// PARAMETERS
//  WIDTH  3  counter width in bits (>=1)
// PORTS
//  CLK     in   1      clock; all state updates on falling edge of CLK
//  RST     in   1      asynchronous reset, active-high
//  EN      in   1      count enable, sampled on falling edge
//  LOAD    in   1      load D into counter and reload register; priority over EN
//  AUTO    in   1      1 = auto-reload at zero, 0 = one-shot (sampled each edge)
//  D       in   WIDTH  preset value
//  Q       out  WIDTH  current count (registered)
//  BORROW  out  1      combinational terminal count: (state==RUN) & EN & (Q==0) & ~LOAD
//  DONE    out  1      registered; 1 while one-shot has expired
// BEHAVIOUR
//  Reset (RST=1, async, any time incl. mid-count):
//  - Q=0, reload reg R=0, DONE=0, state=IDLE.
//  - BORROW=0 while in IDLE.
//  FSM states: IDLE, RUN, EXPIRED. Evaluation on each falling CLK edge, RST=0, first match wins:
//  1. LOAD=1: Q<=D, R<=D, DONE<=0, state<=RUN. Any state; EN ignored this edge.
//  2. IDLE or EXPIRED, LOAD=0: hold everything. EN has no effect.
//  3. RUN, EN=0: hold.
//  4. RUN, EN=1, Q!=0: Q<=Q-1 (no wrap through all-ones).
//  5. RUN, EN=1, Q==0, AUTO=1: Q<=R, stay RUN.
//     BORROW high for exactly this enabled cycle; period = R+1 enabled edges.
//  6. RUN, EN=1, Q==0, AUTO=0: Q holds 0, state<=EXPIRED, DONE<=1.
//     BORROW high for exactly this one cycle.
//  Latency: Q changes one falling edge after the qualifying inputs. BORROW has zero latency (combinational).
//  Boundaries:
//  - D=0 load: next enabled edge is terminal count.
//    AUTO=1 gives BORROW every enabled edge (divide-by-1).
//  - LOAD with EN=1 on the same edge: the load wins, no decrement.
//  - LOAD during EXPIRED: restarts the count and clears DONE.
//  - AUTO toggled mid-count: takes effect at the next zero crossing only.
//  - Arithmetic is unsigned, modulo 2^WIDTH; Q never underflows (zero handled by rules 5/6).
// STRUCTURE
//  - Shared include cnt_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_EXPIRED=2'd2 (2-bit),
//    reused by other counter blocks.
//  - Single module; no sub-module needed.
//  - Registers: Q, R, state, DONE, all in one async-reset negedge process.
//  - BORROW is a continuous assign.
//  - Unused encoding 2'd3 recovers to IDLE.
// TESTING (WIDTH=3, stimulus changes on rising edge)
//  1. Reset: RST pulse mid-count with Q=5 -> Q=0, DONE=0, BORROW=0 immediately, without a clock edge.
//     Then EN=1 with no LOAD -> Q stays 0.
//  2. One-shot: LOAD D=3, AUTO=0, EN=1 -> Q 3,2,1,0.
//     BORROW=1 on the Q=0 cycle only; next edge DONE=1, Q=0 thereafter.
//  3. Auto-reload: LOAD D=2, AUTO=1, EN=1 for 9 edges -> Q 2,1,0,2,1,0,2,1,0.
//     BORROW high once every 3 edges.
//  4. Enable gating: D=4 loaded, EN toggles 1,0,0,1 -> Q 4,3,3,3,2.
//     BORROW never asserted while EN=0 even at Q=0.
//  5. Priority: in RUN with Q=1, LOAD=1 D=6 EN=1 -> Q=6, no decrement.
//     In EXPIRED, LOAD D=1 -> DONE=0, state RUN.
//  6. Edge cases:
//     - D=0, AUTO=1 -> BORROW on every enabled edge, Q stays 0.
//     - D=7 full scale, AUTO=0 -> 8 enabled edges to DONE.

Source files
------------

// File: rtl/sync_down_cnt_pkg.sv
// Shared definitions for the synchronous counter family: FSM state encodings.
package sync_down_cnt_pkg;

    localparam int unsigned CNT_STATE_W = 2;

    typedef enum logic [CNT_STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/sync_down_cnt.sv
// Loadable down counter, falling-edge clocked: counts a preset to zero, then either
// expires (one-shot) or reloads itself (auto-reload, divide-by-(D+1)).
module sync_down_cnt
    import sync_down_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic             AUTO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             BORROW,
    output logic             DONE
);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             zero_c;

    assign zero_c = (q_q == WIDTH'(0));

    // State register: all counter state updates on the falling edge.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            q_q     <= WIDTH'(0);
            r_q     <= WIDTH'(0);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a load always wins, even from the unused encoding.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = done_q;

        if (LOAD) begin
            q_d     = D;
            r_d     = D;
            done_d  = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE, ST_EXPIRED: begin
                end
                ST_RUN: begin
                    if (EN) begin
                        if (!zero_c) begin
                            q_d = q_q - WIDTH'(1);
                        end else if (AUTO) begin
                            q_d = r_q;
                        end else begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Terminal count is combinational so cascaded stages see it on the same edge.
    assign BORROW = (state_q == ST_RUN) & EN & zero_c & ~LOAD;
    assign Q      = q_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_sync_down_cnt.sv
// Bench for sync_down_cnt: directed literal sequences plus randomized traffic
// compared every cycle against a behavioural model of the counter.
module tb_sync_down_cnt;

    localparam int unsigned W = 3;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic         LOAD;
    logic         AUTO;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         BORROW;
    logic         DONE;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_on   = 1'b0;

    // Behavioural model: count value, reload value, running / expired flags.
    int  m_q   = 0;
    int  m_r   = 0;
    bit  m_run = 1'b0;
    bit  m_exp = 1'b0;

    int  e3q[8] = '{1, 0, 2, 1, 0, 2, 1, 0};
    int  e3b[8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    int  e4en[4] = '{1, 0, 0, 1};
    int  e4q[4]  = '{3, 3, 3, 2};
    int  edges;

    sync_down_cnt #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .LOAD   (LOAD),
        .AUTO   (AUTO),
        .D      (D),
        .Q      (Q),
        .BORROW (BORROW),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK or posedge RST) begin
        if (RST) begin
            m_q = 0; m_r = 0; m_run = 1'b0; m_exp = 1'b0;
        end else if (LOAD) begin
            m_q = int'(D); m_r = int'(D); m_run = 1'b1; m_exp = 1'b0;
        end else if (m_run && EN) begin
            if (m_q > 0) m_q = m_q - 1;
            else if (AUTO) m_q = m_r;
            else begin
                m_run = 1'b0;
                m_exp = 1'b1;
            end
        end
    end

    function automatic int exp_borrow();
        return (m_run && EN && (m_q == 0) && !LOAD) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Continuous comparison, sampled on the rising edge away from the active falling edge.
    always @(posedge CLK) begin
        if (chk_on) begin
            check("model Q", int'(Q), m_q);
            check("model DONE", int'(DONE), int'(m_exp));
            check("model BORROW", int'(BORROW), exp_borrow());
        end
    end

    task automatic drive(input bit ld, input int d, input bit en, input bit au);
        @(posedge CLK);
        #1;
        LOAD = ld; D = W'(d); EN = en; AUTO = au;
        #1;
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; AUTO = 1'b0; D = '0;
        #2;
        check("reset Q", int'(Q), 0);
        check("reset DONE", int'(DONE), 0);
        check("reset BORROW", int'(BORROW), 0);
        drive(0, 0, 0, 0);
        RST = 1'b0;
        chk_on = 1'b1;

        // Async reset mid-count
        drive(1, 7, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        check("pre-reset Q", int'(Q), 5);
        drive(0, 0, 1, 0);
        RST = 1'b1;
        #1;
        check("async reset Q", int'(Q), 0);
        check("async reset DONE", int'(DONE), 0);
        check("async reset BORROW", int'(BORROW), 0);
        drive(0, 0, 1, 0);
        RST = 1'b0;
        tick();
        check("idle EN Q", int'(Q), 0);
        check("idle EN BORROW", int'(BORROW), 0);

        // One-shot from 3
        drive(1, 3, 1, 0); tick();
        check("oneshot load Q", int'(Q), 3);
        for (int i = 2; i >= 0; i--) begin
            drive(0, 0, 1, 0);
            check("oneshot borrow low", int'(BORROW), 0);
            tick();
            check("oneshot Q", int'(Q), i);
        end
        drive(0, 0, 1, 0);
        check("oneshot terminal BORROW", int'(BORROW), 1);
        tick();
        check("oneshot DONE", int'(DONE), 1);
        check("oneshot Q held", int'(Q), 0);
        drive(0, 0, 1, 0);
        check("expired BORROW", int'(BORROW), 0);
        tick();
        check("expired Q", int'(Q), 0);

        // Auto-reload divide-by-3
        drive(1, 2, 1, 1); tick();
        check("auto load Q", int'(Q), 2);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 1);
            check("auto BORROW", int'(BORROW), e3b[i]);
            tick();
            check("auto Q", int'(Q), e3q[i]);
            check("auto DONE", int'(DONE), 0);
        end

        // Enable gating
        drive(1, 4, 0, 0); tick();
        check("gate load Q", int'(Q), 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, e4en[i] != 0, 0); tick();
            check("gate Q", int'(Q), e4q[i]);
        end
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        check("gate zero BORROW", int'(BORROW), 0);
        tick();
        check("gate zero Q", int'(Q), 0);
        check("gate zero DONE", int'(DONE), 0);

        // Load priority over decrement, and reload out of EXPIRED
        drive(1, 1, 1, 0); tick();
        drive(1, 6, 1, 0);
        check("prio BORROW", int'(BORROW), 0);
        tick();
        check("prio Q", int'(Q), 6);
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        check("prio expired DONE", int'(DONE), 1);
        drive(1, 1, 0, 0); tick();
        check("reload DONE", int'(DONE), 0);
        check("reload Q", int'(Q), 1);
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 1, 0);
        check("reload running BORROW", int'(BORROW), 1);

        // Divide-by-1
        drive(1, 0, 1, 1); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1);
            check("div1 BORROW", int'(BORROW), 1);
            tick();
            check("div1 Q", int'(Q), 0);
        end

        // Full scale one-shot: 8 enabled edges to DONE
        drive(1, 7, 0, 0); tick();
        edges = 0;
        for (int i = 0; i < 20 && !DONE; i++) begin
            drive(0, 0, 1, 0); tick();
            edges++;
        end
        check("full scale edges", edges, 8);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            RST = ($urandom_range(0, 59) == 0);
            tick();
        end
        drive(0, 0, 0, 0);
        RST = 1'b0;
        tick();
        @(posedge CLK);
        #1;
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
